mem_responder: RTL and testbench
================================

# mem_responder

Multi-channel memory responder: the memory-side endpoint of the per-channel valid/ready request protocol issued by the memory controller. Each channel accepts one read or write request and completes it after a fixed latency into a shared word-addressed storage array. Each channel then holds its ready/data response until the requester drops valid. It serves as the data or program memory behind the controller in simulation and FPGA builds, and includes a backdoor load port for preloading kernels and data.

## Interface
- ADDR_BITS, 8, address width; array depth is 2**ADDR_BITS words
- DATA_BITS, 16, word width
- NUM_CHANNELS, 1, number of independent request channels
- LATENCY, 2, cycles from request acceptance to ready; legal range 1..15
- WRITE_ENABLE, 1, 0 = read-only array (program memory)
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- read_valid  input  [NUM_CHANNELS]  per-channel read request
- read_address  input  [NUM_CHANNELS][ADDR_BITS]  read address
- read_ready  output  [NUM_CHANNELS]  read response valid
- read_data  output  [NUM_CHANNELS][DATA_BITS]  read response data
- write_valid  input  [NUM_CHANNELS]  per-channel write request
- write_address  input  [NUM_CHANNELS][ADDR_BITS]  write address
- write_data  input  [NUM_CHANNELS][DATA_BITS]  write data
- write_ready  output  [NUM_CHANNELS]  write acknowledge
- load_en  input  1  backdoor array write strobe
- load_address  input  ADDR_BITS  backdoor address
- load_data  input  DATA_BITS  backdoor data
- write_violation  output  1  sticky: write completed while WRITE_ENABLE=0

## Operation
- Each channel runs an independent FSM: IDLE -> BUSY -> RESPOND -> IDLE.
- IDLE:
  - read_valid high at an edge: latch address, mark op=read, cnt<=LATENCY-1, go BUSY.
  - Otherwise write_valid high: latch address and data, mark op=write, go BUSY.
  - Read has priority when both valids are high; the write stays pending and is taken on a later IDLE visit.
- BUSY:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0, op=read: read_data<=array[addr], read_ready<=1, go RESPOND.
  - cnt==0, op=write: array[addr]<=data (only if WRITE_ENABLE=1), write_ready<=1, go RESPOND.
  - WRITE_ENABLE=0 write: array unchanged, write_ready still asserted, write_violation<=1.
- RESPOND:
  - ready and read_data are held stable while the latched op's valid is high.
  - When that valid is sampled low: ready<=0, go IDLE. read_data keeps its last value.
- Request inputs are sampled only in IDLE; changes in address or data during BUSY/RESPOND are ignored.
- Same-edge array conflicts:
  - Two channels committing writes to the same address: the highest channel index wins.
  - A channel write commit beats load_en to the same address.
  - A read captured at the same edge as a write commit to the same address returns the pre-write value.
- load_en writes the array at any time, independent of channel state.
- Array contents are not reset.
- cnt width is 4 bits.

## Timing
- Reset (reset_n low, asynchronous): all FSMs IDLE, read_ready=0, write_ready=0, read_data=0, write_violation=0, cnt=0. Pending requests are dropped and no pending write commits.
- Request sampled at edge t: ready rises after edge t+LATENCY. LATENCY=1 gives ready one cycle after acceptance.
- With the controller dropping valid on the edge it sees ready: ready is high for exactly 2 cycles, then the FSM is in IDLE. A new request can be sampled on the following edge.
- Channel occupancy per request with a prompt requester: LATENCY+2 cycles.
- Reset deassertion: the first request can be sampled on the first rising edge after reset_n goes high.

## Test plan
- Preload: load_en writes 0x1234 to addr 0x05; channel 0 read of 0x05 with LATENCY=2 -> read_ready rises 2 cycles after acceptance with read_data=0x1234, then drops after read_valid falls.
- Write then read: channel 0 writes 0xBEEF to 0x10, waits for write_ready, drops valid, then reads 0x10 -> 0xBEEF. Also check write_ready timing equals read_ready timing.
- NUM_CHANNELS=2, same edge: ch0 writes 0x1111 and ch1 writes 0x2222 to 0x20 -> both acknowledged and array[0x20]=0x2222. Then ch0 read while ch1 writes 0x3333 to the same address at the same commit edge -> read returns 0x2222.
- Requester holds read_valid for 5 cycles after ready -> read_ready and read_data remain stable throughout. The FSM returns to IDLE one edge after valid falls, and a back-to-back read is accepted on the next edge.
- WRITE_ENABLE=0: write 0xAAAA to 0x01 holding 0x0042 -> write_ready still handshakes, array[0x01] stays 0x0042, write_violation=1 and remains set until reset.
- Reset mid-BUSY: reset_n pulsed low during a pending write to 0x30 -> ready=0, FSM IDLE, write_violation=0, array[0x30] unchanged.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side endpoint of the per-channel valid/ready request
// protocol. Each channel takes one read or write request, completes it after
// LATENCY cycles against a shared word-addressed array, then holds its
// response until the requester drops valid. A backdoor load port preloads
// the array at any time.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   read_valid/read_address       per-channel read request
//   read_ready/read_data          per-channel read response (held in RESPOND)
//   write_valid/write_address/
//   write_data                    per-channel write request
//   write_ready                   per-channel write acknowledge
//   load_en/load_address/
//   load_data                     backdoor array write
//   write_violation               sticky: write completed with WRITE_ENABLE=0
//
// Channel FSM:
//   state   | meaning
//   IDLE    | sampling read_valid (priority) then write_valid
//   BUSY    | counting down the access latency
//   RESPOND | ready held high until the latched op's valid drops
module mem_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 16,
    parameter int NUM_CHANNELS = 1,
    parameter int LATENCY      = 2,
    parameter int WRITE_ENABLE = 1
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [NUM_CHANNELS-1:0]                 read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  read_address,
    output logic [NUM_CHANNELS-1:0]                 read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  read_data,
    input  logic [NUM_CHANNELS-1:0]                 write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  write_data,
    output logic [NUM_CHANNELS-1:0]                 write_ready,
    input  logic                                    load_en,
    input  logic [ADDR_BITS-1:0]                    load_address,
    input  logic [DATA_BITS-1:0]                    load_data,
    output logic                                    write_violation
);

    typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam int         DEPTH    = 1 << ADDR_BITS;

    state_t                                 state_q [NUM_CHANNELS];
    state_t                                 state_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]                op_wr_q, op_wr_d;
    logic [NUM_CHANNELS-1:0][3:0]           cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] addr_q, addr_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wdata_q, wdata_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rdata_q, rdata_d;
    logic [NUM_CHANNELS-1:0]                rready_q, rready_d;
    logic [NUM_CHANNELS-1:0]                wready_q, wready_d;
    logic [NUM_CHANNELS-1:0]                commit;
    logic                                   violation_q;
    logic [DATA_BITS-1:0]                   mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= IDLE;
            end
            op_wr_q     <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rready_q    <= '0;
            wready_q    <= '0;
            violation_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= state_d[c];
            end
            op_wr_q  <= op_wr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rready_q <= rready_d;
            wready_q <= wready_d;
            if ((WRITE_ENABLE == 0) && (|commit)) begin
                violation_q <= 1'b1;
            end
        end
    end

    always_comb begin
        op_wr_d  = op_wr_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rready_d = rready_q;
        wready_d = wready_q;
        commit   = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                IDLE: begin
                    if (read_valid[c]) begin
                        addr_d[c]  = read_address[c];
                        op_wr_d[c] = 1'b0;
                        cnt_d[c]   = CNT_INIT;
                        state_d[c] = BUSY;
                    end else if (write_valid[c]) begin
                        addr_d[c]  = write_address[c];
                        wdata_d[c] = write_data[c];
                        op_wr_d[c] = 1'b1;
                        cnt_d[c]   = CNT_INIT;
                        state_d[c] = BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q[c] != 4'd0) begin
                        cnt_d[c] = cnt_q[c] - 4'd1;
                    end else if (op_wr_q[c]) begin
                        commit[c]   = 1'b1;
                        wready_d[c] = 1'b1;
                        state_d[c]  = RESPOND;
                    end else begin
                        // Array is read before this edge's writes land,
                        // so a same-edge write returns the old word.
                        rdata_d[c]  = mem[addr_q[c]];
                        rready_d[c] = 1'b1;
                        state_d[c]  = RESPOND;
                    end
                end
                RESPOND: begin
                    if (op_wr_q[c] ? !write_valid[c] : !read_valid[c]) begin
                        rready_d[c] = 1'b0;
                        wready_d[c] = 1'b0;
                        state_d[c]  = IDLE;
                    end
                end
                default: state_d[c] = IDLE;
            endcase
        end
    end

    // Later assignments win: channel commits override load_en, and the
    // highest channel index overrides lower ones at the same address.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_address] <= load_data;
        end
        if (WRITE_ENABLE != 0) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (commit[c]) begin
                    mem[addr_q[c]] <= wdata_q[c];
                end
            end
        end
    end

    assign read_ready      = rready_q;
    assign read_data       = rdata_q;
    assign write_ready     = wready_q;
    assign write_violation = violation_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dut0: two channels, writable
    logic [1:0]        d0_rv, d0_rr, d0_wv, d0_wr;
    logic [1:0][7:0]   d0_ra, d0_wa;
    logic [1:0][15:0]  d0_rd, d0_wd;
    logic              d0_le, d0_viol;
    logic [7:0]        d0_la;
    logic [15:0]       d0_ld;

    // dut1: one channel, read-only array
    logic [0:0]        d1_rv, d1_rr, d1_wv, d1_wr;
    logic [0:0][7:0]   d1_ra, d1_wa;
    logic [0:0][15:0]  d1_rd, d1_wd;
    logic              d1_le, d1_viol;
    logic [7:0]        d1_la;
    logic [15:0]       d1_ld;

    mem_responder #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(2),
                    .LATENCY(LAT), .WRITE_ENABLE(1)) dut0 (
        .clk(clk), .reset_n(rst_n),
        .read_valid(d0_rv), .read_address(d0_ra), .read_ready(d0_rr), .read_data(d0_rd),
        .write_valid(d0_wv), .write_address(d0_wa), .write_data(d0_wd), .write_ready(d0_wr),
        .load_en(d0_le), .load_address(d0_la), .load_data(d0_ld),
        .write_violation(d0_viol));

    mem_responder #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(1),
                    .LATENCY(LAT), .WRITE_ENABLE(0)) dut1 (
        .clk(clk), .reset_n(rst_n),
        .read_valid(d1_rv), .read_address(d1_ra), .read_ready(d1_rr), .read_data(d1_rd),
        .write_valid(d1_wv), .write_address(d1_wa), .write_data(d1_wd), .write_ready(d1_wr),
        .load_en(d1_le), .load_address(d1_la), .load_data(d1_ld),
        .write_violation(d1_viol));

    // Stream index: dut*4 + kind*2 + channel, kind 0 = read, 1 = write
    typedef struct {
        logic [15:0] data;
        int          cycle;
    } exp_t;

    exp_t        exp_q [8][$];
    exp_t        mon_e;
    logic [7:0]  prev_rdy = '0;
    logic [15:0] held [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic get_rdy(input int s);
        case (s)
            0: return d0_rr[0];
            1: return d0_rr[1];
            2: return d0_wr[0];
            3: return d0_wr[1];
            4: return d1_rr[0];
            6: return d1_wr[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] get_dat(input int s);
        case (s)
            0: return d0_rd[0];
            1: return d0_rd[1];
            4: return d1_rd[0];
            default: return 16'h0;
        endcase
    endfunction

    function automatic logic is_read(input int s);
        return (s == 0) || (s == 1) || (s == 4);
    endfunction

    // Monitor: pops an expectation on each rising ready, checks rise cycle
    // and data, then checks data stays stable while ready is held.
    always @(negedge clk) begin
        for (int s = 0; s < 8; s++) begin
            if (get_rdy(s) && !prev_rdy[s]) begin
                if (exp_q[s].size() == 0) begin
                    chk($sformatf("unexpected_ready_s%0d", s), 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q[s].pop_front();
                    chk($sformatf("ready_cycle_s%0d", s), 32'(cyc), 32'(mon_e.cycle));
                    if (is_read(s)) begin
                        chk($sformatf("read_data_s%0d", s), 32'(get_dat(s)), 32'(mon_e.data));
                    end
                    held[s] = mon_e.data;
                end
            end else if (get_rdy(s) && is_read(s)) begin
                chk($sformatf("held_data_s%0d", s), 32'(get_dat(s)), 32'(held[s]));
            end
            prev_rdy[s] = get_rdy(s);
        end
    end

    task automatic set_valid(input int d, input int k, input int ch,
                             input logic [7:0] a, input logic [15:0] wd, input logic v);
        if (d == 0) begin
            if (k == 0) begin
                d0_ra[ch] = a; d0_rv[ch] = v;
            end else begin
                d0_wa[ch] = a; d0_wd[ch] = wd; d0_wv[ch] = v;
            end
        end else begin
            if (k == 0) begin
                d1_ra[0] = a; d1_rv[0] = v;
            end else begin
                d1_wa[0] = a; d1_wd[0] = wd; d1_wv[0] = v;
            end
        end
    endtask

    task automatic load(input int d, input logic [7:0] a, input logic [15:0] v);
        if (d == 0) begin
            d0_la = a; d0_ld = v; d0_le = 1'b1;
        end else begin
            d1_la = a; d1_ld = v; d1_le = 1'b1;
        end
        @(posedge clk); #1;
        d0_le = 1'b0;
        d1_le = 1'b0;
    endtask

    // Issue one request, wait for ready, keep valid for 'hold' extra cycles
    // after seeing ready, drop it, and require ready low one edge later.
    task automatic req(input int d, input int k, input int ch, input logic [7:0] a,
                       input logic [15:0] wd, input logic [15:0] er, input int hold);
        exp_t e;
        int   s;
        int   n;
        s = d * 4 + k * 2 + ch;
        e.data  = er;
        e.cycle = cyc + 1 + LAT;
        exp_q[s].push_back(e);
        set_valid(d, k, ch, a, wd, 1'b1);
        n = 0;
        while (!get_rdy(s) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 30) chk($sformatf("timeout_ready_s%0d", s), 32'd0, 32'd1);
        repeat (hold + 1) @(posedge clk);
        #1;
        set_valid(d, k, ch, a, wd, 1'b0);
        @(posedge clk); #1;
        chk($sformatf("ready_drop_s%0d", s), 32'(get_rdy(s)), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        d0_rv = '0; d0_ra = '0; d0_wv = '0; d0_wa = '0; d0_wd = '0;
        d0_le = 1'b0; d0_la = '0; d0_ld = '0;
        d1_rv = '0; d1_ra = '0; d1_wv = '0; d1_wa = '0; d1_wd = '0;
        d1_le = 1'b0; d1_la = '0; d1_ld = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rready0", 32'(d0_rr), 32'd0);
        chk("reset_wready0", 32'(d0_wr), 32'd0);
        chk("reset_rdata0", 32'(d0_rd), 32'd0);
        chk("reset_viol1", 32'(d1_viol), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // preload then read
        load(0, 8'h05, 16'h1234);
        req(0, 0, 0, 8'h05, 16'h0, 16'h1234, 0);

        // write then read back
        req(0, 1, 0, 8'h10, 16'hBEEF, 16'h0, 0);
        req(0, 0, 0, 8'h10, 16'h0, 16'hBEEF, 0);

        // same-edge writes from both channels: higher channel wins
        fork
            req(0, 1, 0, 8'h20, 16'h1111, 16'h0, 0);
            req(0, 1, 1, 8'h20, 16'h2222, 16'h0, 0);
        join
        req(0, 0, 0, 8'h20, 16'h0, 16'h2222, 0);

        // read captured at the same edge as a write commit sees old value
        fork
            req(0, 0, 0, 8'h20, 16'h0, 16'h2222, 0);
            req(0, 1, 1, 8'h20, 16'h3333, 16'h0, 0);
        join
        req(0, 0, 1, 8'h20, 16'h0, 16'h3333, 0);

        // requester holds valid 5 cycles, then back-to-back read
        req(0, 0, 1, 8'h10, 16'h0, 16'hBEEF, 5);
        req(0, 0, 1, 8'h05, 16'h0, 16'h1234, 0);
        chk("no_violation_dut0", 32'(d0_viol), 32'd0);

        // read-only array: write handshakes but array unchanged, sticky flag
        load(1, 8'h01, 16'h0042);
        chk("viol_before_write", 32'(d1_viol), 32'd0);
        req(1, 1, 0, 8'h01, 16'hAAAA, 16'h0, 0);
        chk("viol_after_write", 32'(d1_viol), 32'd1);
        req(1, 0, 0, 8'h01, 16'h0, 16'h0042, 0);
        chk("viol_sticky", 32'(d1_viol), 32'd1);

        // reset while writes are in BUSY
        load(0, 8'h30, 16'h7777);
        load(1, 8'h30, 16'h7777);
        set_valid(0, 1, 0, 8'h30, 16'h9999, 1'b1);
        set_valid(1, 1, 0, 8'h30, 16'h9999, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_wready0", 32'(d0_wr), 32'd0);
        chk("midreset_rdata0", 32'(d0_rd), 32'd0);
        chk("midreset_viol1", 32'(d1_viol), 32'd0);
        set_valid(0, 1, 0, 8'h30, 16'h9999, 1'b0);
        set_valid(1, 1, 0, 8'h30, 16'h9999, 1'b0);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("postreset_wready0", 32'(d0_wr), 32'd0);
        chk("postreset_wready1", 32'(d1_wr), 32'd0);
        req(0, 0, 0, 8'h30, 16'h0, 16'h7777, 0);
        req(1, 0, 0, 8'h30, 16'h0, 16'h7777, 0);
        chk("postreset_viol1", 32'(d1_viol), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 8; s++) begin
            chk($sformatf("pending_s%0d", s), 32'(exp_q[s].size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
